// File: rtl/aha_soc_reset_ctrl.sv
// aha_soc_reset_ctrl
// Reset and power-handshake controller feeding the CM3 integration block.
// It sequences CPU_PORESETn, CPU_SYSRESETn and DAP_RESETn from the power-on
// reset. It also services system-reset, lockup, debug-reset and debug
// power-up requests with timed pulses and 4-phase acknowledges.
//
// Ports:
//   MASTER_CLK      sole clock
//   PORESET         power-on reset, asynchronous, active-high
//   SYSRESETREQ     core system reset request (level)
//   LOCKUP          core lockup indication (level)
//   DBGRSTREQ       debug reset request
//   DBGPWRUPREQ     debug power-up request
//   DBGSYSPWRUPREQ  system power-up request from debug
//   CPU_PORESETn    core power-on reset, active-low
//   CPU_SYSRESETn   core system reset, active-low
//   DAP_RESETn      DAP reset, active-low
//   DBGRSTACK       debug reset acknowledge
//   DBGPWRUPACK     debug power-up acknowledge
//   DBGSYSPWRUPACK  system power-up acknowledge
//   RESET_CAUSE     last reset cause: 00 POR, 01 SYSRESETREQ, 10 LOCKUP
//
// Main FSM:
//   state   | meaning
//   POR     | counting out the power-on delay, everything held in reset
//   POR_SYS | core/DAP released, system reset released on the next edge
//   RUN     | normal operation, watching for system reset triggers
//   SYS_RST | CPU_SYSRESETn pulse in progress
//
// Debug reset FSM:
//   state   | meaning
//   D_IDLE  | waiting for DBGRSTREQ
//   D_RST   | DAP_RESETn pulse in progress
//   D_ACK   | DBGRSTACK high, waiting for DBGRSTREQ to drop

module aha_soc_reset_ctrl #(
  parameter int POR_CYCLES     = 16,
  parameter int SYS_RST_CYCLES = 8,
  parameter int DBG_RST_CYCLES = 8,
  parameter int PWRUP_DELAY    = 4,
  parameter bit LOCKUP_RST_EN  = 1'b0
) (
  input  logic       MASTER_CLK,
  input  logic       PORESET,
  input  logic       SYSRESETREQ,
  input  logic       LOCKUP,
  input  logic       DBGRSTREQ,
  input  logic       DBGPWRUPREQ,
  input  logic       DBGSYSPWRUPREQ,
  output logic       CPU_PORESETn,
  output logic       CPU_SYSRESETn,
  output logic       DAP_RESETn,
  output logic       DBGRSTACK,
  output logic       DBGPWRUPACK,
  output logic       DBGSYSPWRUPACK,
  output logic [1:0] RESET_CAUSE
);

  typedef enum logic [1:0] {POR, POR_SYS, RUN, SYS_RST} main_state_t;
  typedef enum logic [1:0] {D_IDLE, D_RST, D_ACK} dbg_state_t;

  // Terminal counts: the counters start at 0, so the N-th edge sees N-1.
  localparam logic [7:0] POR_TC = 8'(POR_CYCLES - 1);
  localparam logic [7:0] SYS_TC = 8'(SYS_RST_CYCLES - 1);
  localparam logic [7:0] DBG_TC = 8'(DBG_RST_CYCLES - 1);
  localparam logic [7:0] PWR_TC = 8'(PWRUP_DELAY - 1);

  main_state_t     main_q, main_d;
  dbg_state_t      dbg_q, dbg_d;
  logic [7:0]      main_cnt_q, main_cnt_d;
  logic [7:0]      dbg_cnt_q, dbg_cnt_d;
  logic            porn_q, porn_d;
  logic            sysn_q, sysn_d;
  logic            dapn_q, dapn_d;
  logic            rack_q, rack_d;
  logic [1:0]      cause_q, cause_d;
  logic [1:0]      pwr_req;
  logic [1:0]      pwr_ack_q, pwr_ack_d;
  logic [1:0][7:0] pwr_cnt_q, pwr_cnt_d;
  logic            trigger;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign trigger = SYSRESETREQ | (LOCKUP & LOCKUP_RST_EN);
  assign pwr_req = {DBGSYSPWRUPREQ, DBGPWRUPREQ};

  always_ff @(posedge MASTER_CLK or posedge PORESET) begin
    if (PORESET) begin
      main_q     <= POR;
      dbg_q      <= D_IDLE;
      main_cnt_q <= 8'd0;
      dbg_cnt_q  <= 8'd0;
      porn_q     <= 1'b0;
      sysn_q     <= 1'b0;
      dapn_q     <= 1'b0;
      rack_q     <= 1'b0;
      cause_q    <= 2'b00;
      pwr_ack_q  <= 2'b00;
      pwr_cnt_q  <= '0;
    end else begin
      main_q     <= main_d;
      dbg_q      <= dbg_d;
      main_cnt_q <= main_cnt_d;
      dbg_cnt_q  <= dbg_cnt_d;
      porn_q     <= porn_d;
      sysn_q     <= sysn_d;
      dapn_q     <= dapn_d;
      rack_q     <= rack_d;
      cause_q    <= cause_d;
      pwr_ack_q  <= pwr_ack_d;
      pwr_cnt_q  <= pwr_cnt_d;
    end
  end

  always_comb begin
    main_d     = main_q;
    main_cnt_d = main_cnt_q;
    porn_d     = porn_q;
    sysn_d     = sysn_q;
    cause_d    = cause_q;
    dapn_d     = dapn_q;
    dbg_d      = dbg_q;
    dbg_cnt_d  = dbg_cnt_q;
    rack_d     = rack_q;

    case (main_q)
      POR: begin
        if (main_cnt_q == POR_TC) begin
          porn_d     = 1'b1;
          dapn_d     = 1'b1;
          main_cnt_d = 8'd0;
          main_d     = POR_SYS;
        end else begin
          main_cnt_d = sat_inc(main_cnt_q);
        end
      end
      POR_SYS: begin
        sysn_d = 1'b1;
        main_d = RUN;
      end
      RUN: begin
        if (trigger) begin
          sysn_d     = 1'b0;
          cause_d    = SYSRESETREQ ? 2'b01 : 2'b10;
          main_cnt_d = 8'd0;
          main_d     = SYS_RST;
        end
      end
      SYS_RST: begin
        // Requests are not sampled here; a held trigger is seen again in RUN,
        // giving at least one high cycle between pulses.
        if (main_cnt_q == SYS_TC) begin
          sysn_d     = 1'b1;
          main_cnt_d = 8'd0;
          main_d     = RUN;
        end else begin
          main_cnt_d = sat_inc(main_cnt_q);
        end
      end
      default: main_d = POR;
    endcase

    // The debug FSM owns DAP_RESETn only once the power-on sequence is done.
    if (main_q != POR) begin
      case (dbg_q)
        D_IDLE: begin
          if (DBGRSTREQ) begin
            dapn_d    = 1'b0;
            dbg_cnt_d = 8'd0;
            dbg_d     = D_RST;
          end
        end
        D_RST: begin
          if (dbg_cnt_q == DBG_TC) begin
            dapn_d    = 1'b1;
            rack_d    = 1'b1;
            dbg_cnt_d = 8'd0;
            dbg_d     = D_ACK;
          end else begin
            dbg_cnt_d = sat_inc(dbg_cnt_q);
          end
        end
        D_ACK: begin
          if (!DBGRSTREQ) begin
            rack_d = 1'b0;
            dbg_d  = D_IDLE;
          end
        end
        default: dbg_d = D_IDLE;
      endcase
    end
  end

  // Power-up channels: ack follows req only after a run of PWRUP_DELAY
  // consecutive mismatch cycles, so short req glitches are filtered out.
  always_comb begin
    pwr_ack_d = pwr_ack_q;
    pwr_cnt_d = pwr_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (main_q == POR) begin
        pwr_ack_d[i] = 1'b0;
        pwr_cnt_d[i] = 8'd0;
      end else if (pwr_req[i] == pwr_ack_q[i]) begin
        pwr_cnt_d[i] = 8'd0;
      end else if (pwr_cnt_q[i] == PWR_TC) begin
        pwr_ack_d[i] = pwr_req[i];
        pwr_cnt_d[i] = 8'd0;
      end else begin
        pwr_cnt_d[i] = sat_inc(pwr_cnt_q[i]);
      end
    end
  end

  assign CPU_PORESETn   = porn_q;
  assign CPU_SYSRESETn  = sysn_q;
  assign DAP_RESETn     = dapn_q;
  assign DBGRSTACK      = rack_q;
  assign DBGPWRUPACK    = pwr_ack_q[0];
  assign DBGSYSPWRUPACK = pwr_ack_q[1];
  assign RESET_CAUSE    = cause_q;

endmodule
